execute_pipe: RTL and testbench

Parametrised, registered execute stage for the WISC pipeline. It accepts one decoded instruction per cycle from ID/EX over a valid/ready handshake and computes the ALU result, branch decision and next PC. It places the results in its own EX/MEM output register. An optional iterative multiplier adds a multi-cycle mode that stalls the upstream stage. It sits between decode and the memory stage and supplies newPC back to fetch.

---
 rtl/execute_pipe.sv | 188 ++++++++++++++++++
 tb/tb_execute_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_pipe.sv
// WISC execute stage: registered ALU, branch resolution and next-PC with a valid/ready EX/MEM output register.
// Optional iterative shift-and-add multiplier for aluOp 111, enabled by defining EXEC_MULT_EN.
module execute_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       aluOp,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] pcInc,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluOut,
    output logic [WIDTH-1:0] newPC,
    output logic             brTaken,
    output logic             ofl,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic [WIDTH-1:0] new_pc_q, new_pc_d;
    logic             br_taken_q, br_taken_d;
    logic             ofl_q, ofl_d;

    logic [WIDTH-1:0] res_alu, res_pc, sum, diff;
    logic             res_ofl, res_taken;
    logic             out_free, accept;

    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign sum      = inA + inB;
    assign diff     = inB - inA;

    always_comb begin
        res_alu   = '0;
        res_ofl   = 1'b0;
        res_taken = 1'b0;
        case (aluOp)
            3'b000: begin
                res_alu = sum;
                res_ofl = (inA[MSB] == inB[MSB]) && (sum[MSB] != inA[MSB]);
            end
            3'b001: begin
                res_alu = diff;
                res_ofl = (inB[MSB] != inA[MSB]) && (diff[MSB] != inB[MSB]);
            end
            3'b010: res_alu = inA & inB;
            3'b011: res_alu = inA ^ inB;
            3'b100: res_alu = {{(WIDTH-1){1'b0}}, ($signed(inA) < $signed(inB))};
            3'b101: res_taken = (inA == '0);
            3'b110: res_taken = (inA != '0);
            default: res_alu = '0;
        endcase
        res_pc = res_taken ? (pcInc + imm) : pcInc;
    end

`ifdef EXEC_MULT_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [WIDTH-1:0] mul_pc_q, mul_pc_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_next;
    logic             is_mul, mul_last, mul_done;

    assign is_mul   = (aluOp == 3'b111);
    assign acc_next = acc_q + (mul_b_q[count_q] ? (mul_a_q << count_q) : '0);
    assign mul_last = (state_q == MUL) && (count_q == LAST);
    // The final partial product is only folded in once the output register can take it.
    assign mul_done = mul_last && out_free;
    assign in_ready = !rst && (state_q == IDLE) && out_free;
    assign busy     = (state_q == MUL);
`else
    logic is_mul;

    assign is_mul   = 1'b0;
    assign in_ready = !rst && out_free;
    assign busy     = 1'b0;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        alu_out_d   = alu_out_q;
        new_pc_d    = new_pc_q;
        br_taken_d  = br_taken_q;
        ofl_d       = ofl_q;
`ifdef EXEC_MULT_EN
        state_d  = state_q;
        count_d  = count_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        mul_pc_d = mul_pc_q;
        acc_d    = acc_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
`ifdef EXEC_MULT_EN
            state_d = IDLE;
`endif
        end else begin
`ifdef EXEC_MULT_EN
            if (mul_done) begin
                out_valid_d = 1'b1;
                alu_out_d   = acc_next;
                new_pc_d    = mul_pc_q;
                br_taken_d  = 1'b0;
                ofl_d       = 1'b0;
                state_d     = IDLE;
            end else
`endif
            if (accept && !is_mul) begin
                out_valid_d = 1'b1;
                alu_out_d   = res_alu;
                new_pc_d    = res_pc;
                br_taken_d  = res_taken;
                ofl_d       = res_ofl;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
`ifdef EXEC_MULT_EN
            if ((state_q == IDLE) && accept && is_mul) begin
                state_d  = MUL;
                count_d  = '0;
                acc_d    = '0;
                mul_a_d  = inA;
                mul_b_d  = inB;
                mul_pc_d = pcInc;
            end else if ((state_q == MUL) && !mul_last) begin
                acc_d   = acc_next;
                count_d = count_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            new_pc_q    <= '0;
            br_taken_q  <= 1'b0;
            ofl_q       <= 1'b0;
`ifdef EXEC_MULT_EN
            state_q  <= IDLE;
            count_q  <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            mul_pc_q <= '0;
            acc_q    <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            new_pc_q    <= new_pc_d;
            br_taken_q  <= br_taken_d;
            ofl_q       <= ofl_d;
`ifdef EXEC_MULT_EN
            state_q  <= state_d;
            count_q  <= count_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            mul_pc_q <= mul_pc_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign aluOut    = alu_out_q;
    assign newPC     = new_pc_q;
    assign brTaken   = br_taken_q;
    assign ofl       = ofl_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe: directed cases then randomized traffic with back-pressure and flushes.
// Expected results come from an arithmetic reference model; define EXEC_MULT_EN to exercise the multiplier.
module tb_execute_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]   aluOp;
    logic [W-1:0] inA, inB, pcInc, imm, aluOut, newPC;
    logic         brTaken, ofl, busy;

    typedef struct packed {
        logic [W-1:0] alu;
        logic [W-1:0] pc;
        logic         br;
        logic         ofl;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   randReady = 1'b0;

    execute_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluOp(aluOp), .inA(inA), .inB(inB), .pcInc(pcInc), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluOut(aluOut), .newPC(newPC), .brTaken(brTaken), .ofl(ofl), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the instruction's semantics.
    function automatic exp_t refModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] pc, input logic [W-1:0] im);
        exp_t   e;
        int     sa, sb, s;
        longint p;
        e    = '0;
        e.pc = pc;
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        case (op)
            3'd0: begin s = sa + sb; e.alu = a + b; e.ofl = (s > 32767) || (s < -32768); end
            3'd1: begin s = sb - sa; e.alu = b - a; e.ofl = (s > 32767) || (s < -32768); end
            3'd2: e.alu = a & b;
            3'd3: e.alu = a ^ b;
            3'd4: e.alu = (sa < sb) ? 16'd1 : 16'd0;
            3'd5: if (a == 0) begin e.br = 1'b1; e.pc = pc + im; end
            3'd6: if (a != 0) begin e.br = 1'b1; e.pc = pc + im; end
            default: begin
`ifdef EXEC_MULT_EN
                p     = longint'(a) * longint'(b);
                e.alu = p[W-1:0];
`else
                p     = 0;
                e.alu = '0;
`endif
            end
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drive one instruction and push its expected result when the DUT accepts it.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] pc, input logic [W-1:0] im);
        bit accepted;
        accepted = 1'b0;
        aluOp    = op;
        inA      = a;
        inB      = b;
        pcInc    = pc;
        imm      = im;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready && !flush && !rst) begin
                sbq.push_back(refModel(op, a, b, pc, im));
                accepted = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=0 expected=1");
        end
    endtask

    // Monitor: compare the scoreboard head whenever a result is presented, pop on retirement.
    always @(negedge clk) begin
        exp_t e;
        if (rst || flush) begin
            sbq.delete();
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output actual=1 expected=0");
            end else begin
                e = sbq[0];
                checkOutput("sb_aluOut", aluOut, e.alu);
                checkOutput("sb_newPC", newPC, e.pc);
                checkOutput("sb_brTaken", brTaken, e.br);
                checkOutput("sb_ofl", ofl, e.ofl);
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        aluOp = '0; inA = '0; inB = '0; pcInc = '0; imm = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_aluOut", aluOut, 0);
        checkOutput("rst_newPC", newPC, 0);
        checkOutput("rst_brTaken", brTaken, 0);
        checkOutput("rst_ofl", ofl, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        $display("[TB] directed ADD overflow");
        applyStimulus(3'd0, 16'h7FFF, 16'h0001, 16'h0010, 16'h0000);
        @(negedge clk);
        checkOutput("add_valid", out_valid, 1);
        checkOutput("add_alu", aluOut, 16'h8000);
        checkOutput("add_ofl", ofl, 1);
        checkOutput("add_pc", newPC, 16'h0010);
        @(posedge clk); #1;

        $display("[TB] directed back-to-back SUB/SLT");
        applyStimulus(3'd1, 16'd3, 16'd10, 16'h0020, 16'h0000);
        fork
            applyStimulus(3'd4, 16'hFFFF, 16'h0001, 16'h0022, 16'h0000);
            begin
                @(negedge clk);
                checkOutput("sub_valid", out_valid, 1);
                checkOutput("sub_alu", aluOut, 16'h0007);
                checkOutput("b2b_in_ready", in_ready, 1);
            end
        join
        @(negedge clk);
        checkOutput("slt_valid", out_valid, 1);
        checkOutput("slt_alu", aluOut, 16'h0001);
        @(posedge clk); #1;

        $display("[TB] directed branches");
        applyStimulus(3'd5, 16'h0000, 16'h0000, 16'h0100, 16'hFFFC);
        @(negedge clk);
        checkOutput("beqz_br", brTaken, 1);
        checkOutput("beqz_pc", newPC, 16'h00FC);
        checkOutput("beqz_alu", aluOut, 0);
        @(posedge clk); #1;
        applyStimulus(3'd6, 16'h0000, 16'h0000, 16'h0100, 16'hFFFC);
        @(negedge clk);
        checkOutput("bnez_br", brTaken, 0);
        checkOutput("bnez_pc", newPC, 16'h0100);
        @(posedge clk); #1;

        $display("[TB] directed MUL");
        applyStimulus(3'd7, 16'h0123, 16'h0010, 16'h0200, 16'h0000);
`ifdef EXEC_MULT_EN
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            checkOutput("mul_busy", busy, 1);
            checkOutput("mul_in_ready", in_ready, 0);
        end
        @(negedge clk);
        checkOutput("mul_valid", out_valid, 1);
        checkOutput("mul_alu", aluOut, 16'h1230);
        checkOutput("mul_busy_done", busy, 0);
`else
        @(negedge clk);
        checkOutput("mul_valid", out_valid, 1);
        checkOutput("mul_alu", aluOut, 0);
        checkOutput("mul_busy", busy, 0);
`endif
        @(posedge clk); #1;

        $display("[TB] directed back-pressure");
        out_ready = 1'b0;
        applyStimulus(3'd0, 16'd5, 16'd6, 16'h0300, 16'h0000);
        fork
            applyStimulus(3'd0, 16'd2, 16'd2, 16'h0302, 16'h0000);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready", in_ready, 0);
                    checkOutput("bp_alu_hold", aluOut, 16'd11);
                end
                @(posedge clk); #1 out_ready = 1'b1;
                @(negedge clk);
                checkOutput("bp_release_in_ready", in_ready, 1);
            end
        join
        @(negedge clk);
        checkOutput("bp_next_valid", out_valid, 1);
        checkOutput("bp_next_alu", aluOut, 16'd4);
        @(posedge clk); #1;

        for (int run = 0; run < 2; run++) begin
            $display("[TB] abort MUL with %s", (run == 0) ? "flush" : "rst");
            applyStimulus(3'd7, 16'd7, 16'd9, 16'h0400, 16'h0000);
            repeat (4) @(posedge clk);
            #1;
            if (run == 0) flush = 1'b1; else rst = 1'b1;
            if (run == 1) begin
                @(negedge clk);
                checkOutput("rst_hold_in_ready", in_ready, 0);
            end
            @(posedge clk); #1 flush = 1'b0; rst = 1'b0;
            @(negedge clk);
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_valid", out_valid, 0);
            @(posedge clk); #1;
            applyStimulus(3'd0, 16'd1, 16'd1, 16'h0500, 16'h0000);
            @(negedge clk);
            checkOutput("abort_add_valid", out_valid, 1);
            checkOutput("abort_add_alu", aluOut, 16'd2);
            @(posedge clk); #1;
        end

        $display("[TB] randomized traffic");
        randReady = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                flush = 1'b1;
                @(posedge clk); #1 flush = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end else begin
                op = 3'($urandom_range(0, 7));
                if (op == 3'd7 && $urandom_range(0, 3) != 0) op = 3'd0;
                a = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                b = 16'($urandom);
                applyStimulus(op, a, b, 16'($urandom), 16'($urandom));
            end
        end

        randReady = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        checkOutput("drain_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
